// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow and selectable standard or FWFT read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int         AW   = $clog2(DEPTH);
  localparam int         PW   = ptr_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must be within 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be within 0..DEPTH-1");
  end
  if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_mode
    $error("sync_fifo_flags: FWFT must be 0 or 1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  // Flags come from registered pointers only, never from this cycle's requests.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A write on full rides along with a read, which is always legal when full.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Next-state for pointers and sticky error flags; a new error beats clr_err.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    overflow_d  = (overflow_q  && !clr_err) || (wr_en && !wr_acc);
    underflow_d = (underflow_q && !clr_err) || (rd_en && !rd_acc);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    // Capture the head word on an accepted pop, otherwise hold.
    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = rd_data;
    end

    // Registered read data, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign dout = dout_q;
  end else begin : g_fwft
    assign dout = rd_data;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode instance with default thresholds
// and an FWFT instance with AF=6/AE=2 share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] din;

  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [3:0] count_s, count_f;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mq [$];
  logic       m_ovf, m_udf;
  logic [7:0] m_dout;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .clr_err(clr_err), .dout(dout_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
    .overflow(ovf_s), .underflow(udf_s)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) dut_fw (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .clr_err(clr_err), .dout(dout_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ovf_f), .underflow(udf_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = 8'h00;
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    chk("count_std",  32'(count_s), n);
    chk("count_fw",   32'(count_f), n);
    chk("empty_std",  32'(empty_s), 32'(n == 0));
    chk("empty_fw",   32'(empty_f), 32'(n == 0));
    chk("full_std",   32'(full_s),  32'(n == 8));
    chk("full_fw",    32'(full_f),  32'(n == 8));
    chk("afull_std",  32'(af_s),    32'(n >= 7));
    chk("aempty_std", 32'(ae_s),    32'(n <= 1));
    chk("afull_fw",   32'(af_f),    32'(n >= 6));
    chk("aempty_fw",  32'(ae_f),    32'(n <= 2));
    chk("ovf_std",    32'(ovf_s),   32'(m_ovf));
    chk("udf_std",    32'(udf_s),   32'(m_udf));
    chk("ovf_fw",     32'(ovf_f),   32'(m_ovf));
    chk("udf_fw",     32'(udf_f),   32'(m_udf));
    chk("dout_std",   32'(dout_s),  32'(m_dout));
    if (n != 0) chk("dout_fw", 32'(dout_f), 32'(mq[0]));
  endtask

  // One clock cycle: drive at the falling edge, update model at the rising
  // edge, check at the next falling edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    int  n;
    bit  racc, wacc;
    wr_en   = w;
    rd_en   = r;
    din     = d;
    clr_err = c;
    @(posedge clk);
    n    = mq.size();
    racc = r && (n != 0);
    wacc = w && ((n < 8) || r);
    if (racc) m_dout = mq.pop_front();
    if (wacc) mq.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wacc);
    m_udf = (m_udf && !c) || (r && !racc);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [7:0] v;
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    din     = 8'h00;
    model_reset();

    // Reset state, seen before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Write AA, BB, CC then pop three.
    step(1, 0, 8'hAA, 0);
    step(1, 0, 8'hBB, 0);
    step(1, 0, 8'hCC, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);
    chk("dout_last_cc", 32'(dout_s), 32'h0000_00CC);

    // Fill with 0..7, overflow attempt with FF, drain.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i), 0);
    step(1, 0, 8'hFF, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);
    chk("dout_after_drain", 32'(dout_s), 32'h0000_0007);
    step(0, 0, 8'h00, 1);

    // Full with simultaneous write and read for four cycles.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);

    // Wrap-around: 20 write/read pairs at occupancy 3.
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom_range(0, 255));
      step(1, 1, v, 0);
    end
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0);

    // Read on empty, then clear; write+read on empty; clear colliding with a new error.
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h5A, 0);
    step(0, 1, 8'h00, 0);
    step(1, 1, 8'h66, 0);
    step(0, 1, 8'h00, 1);
    step(0, 1, 8'h00, 1);
    step(0, 0, 8'h00, 1);

    // Threshold walk up to occupancy 5, then asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h70 + i), 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised next-generation synchronous FIFO for the datapath buffering layer: single-clock, power-of-two depth, selectable standard or first-word-fall-through (FWFT) read mode. Adds programmable almost-full/almost-empty thresholds, an occupancy count, simultaneous read/write on full, and sticky overflow/underflow error flags. It drops in wherever the existing 8x8 FIFO is used. With default parameters and the extra outputs left unconnected, it behaves identically to that FIFO.

## Interface
- WIDTH, 8, data word width (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- rd_en  in  1  read (pop) request
- din  in  WIDTH  write data
- clr_err  in  1  synchronous clear of overflow/underflow
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The extra MSB is the wrap bit. Both increment modulo 2*DEPTH.
- count = wr_ptr - rd_ptr, computed at pointer width.
- full, empty, almost_* and count are decoded combinationally from the registered pointers only. They never depend on the current wr_en/rd_en.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_en). A write on full is accepted only together with a simultaneous read, which is always accepted because full implies non-empty.
- Write on empty together with a read: the write is accepted and the read is rejected. count becomes 1 and underflow is set.
- Write path: on wr_acc, mem[wr_ptr] <= din and wr_ptr increments.
- Read path: on rd_acc, rd_ptr increments.
- Standard mode: on rd_acc, dout <= mem[rd_ptr] at the same edge. Otherwise dout holds its last value.
- FWFT mode: dout = mem[rd_ptr[$clog2(DEPTH)-1:0]], read combinationally. dout is valid whenever !empty and is don't-care when empty. rd_en acknowledges the current word.
- Error flags:
  - overflow is set on wr_en && !wr_acc. underflow is set on rd_en && !rd_acc.
  - Both hold until a clr_err cycle clears them.
  - If a new error occurs in the same cycle as clr_err, the set wins.
- Rejected operations do not change pointers, memory or dout.
- Reset (asynchronous, any time including mid-burst):
  - Pointers go to 0. count=0, empty=1, full=0.
  - almost_empty=1. almost_full=0.
  - overflow=underflow=0. Standard-mode dout=0.
  - Memory contents are not reset.

## Timing
- Write-to-flag latency: empty deasserts and count increments at the wr_acc edge, so they are visible in the following cycle.
- Standard read latency: 1 cycle. Data appears after the edge that samples rd_en.
- FWFT read latency: the first word is on dout in the cycle after the write edge, simultaneously with empty falling. The next word appears right after the rd_acc edge.
- Simultaneous wr_acc and rd_acc: count is unchanged and both pointers advance. This holds when full as well; the freed slot is the one being written.
- Throughput: one write and one read per cycle sustained. No bubbles at wrap-around.

## Structure
- Package fifo_pkg holds:
  - fifo_mode_e enum {FIFO_STD, FIFO_FWFT}
  - function ptr_w(depth) = $clog2(depth)+1
- Sub-module fifo_ram: simple dual-port memory with a synchronous write port and an asynchronous read port, parameterised by WIDTH and DEPTH.
- sync_fifo_flags contains the pointers, flags, error logic and standard-mode output register.
- Elaboration-time checks: $error if DEPTH is not a power of two, or if either threshold is out of range.

## Test plan
- Standard mode, write AA, BB, CC then pop 3 -> dout is AA, BB, CC, each one cycle after its rd_en edge. empty=1 afterwards and count goes 3, 2, 1, 0.
- Fill DEPTH=8 with 0..7 -> full=1, count=8. Then write FF -> rejected and overflow=1. Pop 8 -> 0..7, then FF is never seen.
- Full FIFO with wr_en and rd_en held together for 4 cycles using din 10..13 -> count stays 8 and no overflow. Draining gives 4..7 then 10..13.
- Wrap-around: 20 write/read pairs at count 3 -> output order is exact across the pointer wrap and the wrap bit toggles twice.
- FWFT mode, write 5A on empty -> next cycle empty=0 and dout=5A with no rd_en. rd_en on empty -> underflow=1; clr_err then clears it.
- Thresholds AF=6, AE=2: almost_full rises at count 6, almost_empty falls at count 3. Assert rst_n=0 at count 5 -> all flags return to their reset values immediately without waiting for a clock.
